// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEFAULT_FLOORS = 4;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer for one call button, with an optional stability filter
// enabled by the ELEVATOR_DEBOUNCE_EN macro. Output is the conditioned level.
module button_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef ELEVATOR_DEBOUNCE_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    generate
        if (FILTER_EN && (DEBOUNCE_CYCLES > 0)) begin : g_filter
            localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [DW-1:0] stable_cnt;
            logic          held;

            // The accepted level follows sync2 only after it has differed for the full window.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_cnt <= '0;
                    held       <= 1'b0;
                end else if (sync2 == held) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    held       <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end

            assign dout = held;
        end else begin : g_bypass
            assign dout = sync2;
        end
    endgenerate

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car controller: latches call edges into pending requests and walks the car
// floor by floor, serving requests ahead before reversing. Optional macro: ELEVATOR_DEBOUNCE_EN.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int  FLOORS          = DEFAULT_FLOORS,
    parameter int  TRAVEL_CYCLES   = 12000000,
    parameter int  DOOR_CYCLES     = 24000000,
    parameter int  DEBOUNCE_CYCLES = 120000,
    localparam int FW              = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] call,
    output logic [FLOORS-1:0] pending,
    output logic [FW-1:0]     floor,
    output logic              dir,
    output logic              moving,
    output logic              door_open,
    output logic              busy,
    output state_t            fsm_state
);

    // One counter serves both travel and door timing since the states are exclusive.
    localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

    logic [FLOORS-1:0] level;
    logic [FLOORS-1:0] level_q;
    logic [FLOORS-1:0] rise;

    genvar g;
    generate
        for (g = 0; g < FLOORS; g++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (call[g]),
                .dout (level[g])
            );
        end
    endgenerate

    assign rise = level & ~level_q;

    state_t            state;
    state_t            state_n;
    logic [FW-1:0]     floor_n;
    logic [FW-1:0]     step_floor;
    logic              dir_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [FLOORS-1:0] above;
    logic [FLOORS-1:0] below;
    logic [FLOORS-1:0] here;
    logic [FLOORS-1:0] ahead;
    logic [FLOORS-1:0] behind;
    logic [FLOORS-1:0] clr_mask;
    logic [FLOORS-1:0] block_mask;
    logic [FLOORS-1:0] pending_n;

    assign fsm_state = state;

    always_comb begin
        above = '0;
        below = '0;
        here  = '0;
        for (int i = 0; i < FLOORS; i++) begin
            above[i] = pending[i] && (i > int'(floor));
            below[i] = pending[i] && (i < int'(floor));
            here[i]  = (i == int'(floor));
        end
        ahead  = (dir == DIR_UP) ? above : below;
        behind = (dir == DIR_UP) ? below : above;
        if (dir == DIR_UP) begin
            step_floor = (floor == FW'(FLOORS - 1)) ? floor : floor + 1'b1;
        end else begin
            step_floor = (floor == '0) ? floor : floor - 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        floor_n    = floor;
        dir_n      = dir;
        cnt_n      = cnt;
        clr_mask   = '0;
        block_mask = '0;
        case (state)
            IDLE: begin
                if (|(rise & here)) begin
                    state_n  = DOOR;
                    cnt_n    = DOOR_LOAD;
                    clr_mask = here;
                end else if (|ahead) begin
                    state_n = MOVE;
                    cnt_n   = TRAVEL_LOAD;
                end else if (|behind) begin
                    state_n = MOVE;
                    dir_n   = (dir == DIR_UP) ? DIR_DN : DIR_UP;
                    cnt_n   = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (cnt == '0) begin
                    floor_n = step_floor;
                    cnt_n   = TRAVEL_LOAD;
                    if (pending[step_floor]) begin
                        state_n              = DOOR;
                        cnt_n                = DOOR_LOAD;
                        clr_mask[step_floor] = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DOOR: begin
                // A press at the open floor holds the door rather than queueing a request.
                block_mask = here;
                if (|(rise & here)) begin
                    cnt_n = DOOR_LOAD;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (|ahead) begin
                    state_n = MOVE;
                    cnt_n   = TRAVEL_LOAD;
                end else if (|behind) begin
                    state_n = MOVE;
                    dir_n   = (dir == DIR_UP) ? DIR_DN : DIR_UP;
                    cnt_n   = TRAVEL_LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        pending_n = (pending | (rise & ~block_mask)) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            floor     <= '0;
            dir       <= DIR_UP;
            cnt       <= '0;
            pending   <= '0;
            level_q   <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            floor     <= floor_n;
            dir       <= dir_n;
            cnt       <= cnt_n;
            pending   <= pending_n;
            level_q   <= level;
            moving    <= (state_n == MOVE);
            door_open <= (state_n == DOOR);
            busy      <= (state_n != IDLE);
        end
    end

endmodule
